// File: rtl/monostable.sv
// monostable: clocked 555-style one-shot producing a DURATION-cycle pulse on q and a
// one-cycle active-low _done strobe on expiry.
module monostable #(
   parameter int WIDTH     = 24,
   parameter int DURATION  = 12_000_000,
   parameter bit RETRIGGER = 1'b0
) (
   input  logic             mclk,
   input  logic             _rst,
   input  logic             _trig,
   input  logic             _clr,
   output logic             q,
   output logic             _q,
   output logic             _done,
   output logic [WIDTH-1:0] remain
);
   typedef enum logic [1:0] {IDLE, TIMING, STRETCH} state_t;
   localparam logic [WIDTH-1:0] LOAD = WIDTH'(DURATION - 1);
   state_t           state;
   logic [WIDTH-1:0] cnt;
   always_ff @(posedge mclk) begin
      _done <= 1'b1;
      if (!_rst || !_clr) begin
         state <= IDLE;
         q     <= 1'b0;
         cnt   <= '0;
      end else if (state == IDLE) begin
         if (!_trig) begin
            state <= TIMING;
            q     <= 1'b1;
            cnt   <= LOAD;
         end
      end else if (RETRIGGER && !_trig) begin
         state <= TIMING;
         cnt   <= LOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end else if (!_trig) begin
         state <= STRETCH;
      end else begin
         // expiry needs the trigger released; q and _done fall on the same edge
         state <= IDLE;
         q     <= 1'b0;
         _done <= 1'b0;
      end
   end
   assign _q     = ~q;
   assign remain = (state == IDLE) ? '0 : cnt;
endmodule

// File: tb/tb_monostable.sv
// tb_monostable: runs a level-mode and a retrigger-mode one-shot side by side against
// a deadline-based reference model under directed and random stimulus.
module tb_monostable;
   localparam int W = 8;
   localparam int D = 5;
   logic         mclk = 1'b0;
   logic         rst = 1'b0, trig = 1'b1, clr = 1'b1;
   logic         q [2];
   logic         q_n [2];
   logic         done [2];
   logic [W-1:0] remain [2];
   int           checks = 0, errors = 0;
   int           k = 0;
   bit           act [2];
   bit           exp_done [2];
   int           endc [2];

   always #5 mclk = ~mclk;

   monostable #(.WIDTH(W), .DURATION(D), .RETRIGGER(1'b0)) u_mono0 (
      .mclk(mclk), ._rst(rst), ._trig(trig), ._clr(clr),
      .q(q[0]), ._q(q_n[0]), ._done(done[0]), .remain(remain[0]));
   monostable #(.WIDTH(W), .DURATION(D), .RETRIGGER(1'b1)) u_mono1 (
      .mclk(mclk), ._rst(rst), ._trig(trig), ._clr(clr),
      .q(q[1]), ._q(q_n[1]), ._done(done[1]), .remain(remain[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, k, obs, exp);
      end
   endtask

   // the pulse is described by its deadline: q falls at endc unless trig holds it
   task automatic model(input int r);
      int cb;
      exp_done[r] = 1'b1;
      if (!rst || !clr) act[r] = 1'b0;
      else if (!act[r]) begin
         if (!trig) begin
            act[r]  = 1'b1;
            endc[r] = k + D;
         end
      end else begin
         cb = (endc[r] > k) ? endc[r] - k : 0;
         if (r == 1 && !trig) endc[r] = k + D;
         else if (cb == 0 && trig) begin
            act[r]      = 1'b0;
            exp_done[r] = 1'b0;
         end
      end
   endtask

   task automatic step(input logic t, input logic c, input logic rs);
      int er;
      @(negedge mclk);
      trig = t;
      clr  = c;
      rst  = rs;
      @(posedge mclk);
      for (int r = 0; r < 2; r++) model(r);
      #1;
      for (int r = 0; r < 2; r++) begin
         er = (act[r] && endc[r] - k - 1 > 0) ? endc[r] - k - 1 : 0;
         check($sformatf("q%0d", r), 32'(q[r]), 32'(act[r]));
         check($sformatf("q_n%0d", r), 32'(q_n[r]), 32'(!act[r]));
         check($sformatf("done%0d", r), 32'(done[r]), 32'(exp_done[r]));
         check($sformatf("remain%0d", r), 32'(remain[r]), 32'(er));
      end
      k++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1);
   endtask

   initial begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("reset_q", 32'(q[0]), 32'd0);
      check("reset_q_n", 32'(q_n[0]), 32'd1);
      check("reset_done", 32'(done[0]), 32'd1);
      check("reset_remain", 32'(remain[1]), 32'd0);
      step(1'b0, 1'b1, 1'b1); idle(8);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
      idle(8);
      step(1'b0, 1'b1, 1'b1); idle(2); step(1'b0, 1'b1, 1'b1); idle(8);
      step(1'b0, 1'b1, 1'b1); idle(1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
      idle(3);
      step(1'b0, 1'b1, 1'b1); idle(1); step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1); idle(7);
      step(1'b0, 1'b1, 1'b1); idle(5); step(1'b0, 1'b1, 1'b1); idle(7);
      step(1'b0, 1'b1, 1'b1); idle(0);
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 99) >= 30), 1'($urandom_range(0, 99) >= 4),
              1'($urandom_range(0, 99) >= 2));
      idle(12);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
